// File: rtl/stack_arbiter.sv
// -----------------------------------------------------------------------------
// stack_arbiter
//
// Shares one stack_memory instance between NUM_REQ requesters. A round-robin
// scan grants at most one push or pop per cycle. Pushes are issued to the stack
// combinationally in the grant cycle and acknowledged one cycle later. Pops are
// issued in the grant cycle. The stack registers dout on that edge. The word is
// captured during the RD cycle and returned with rsp_valid/req_ack one cycle
// after that, so a pop completes two cycles after issue.
//
// Optional feature macro: STK_ARB_ERR_EN
//   defined   : a push on full / pop on empty still wins the scan. It is not
//               sent to the stack and is acked with rsp_err=1.
//   undefined : such requests are ineligible and wait. The rsp_err port is
//               absent.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous, active-low reset
//   req        per-requester request, held high until req_ack
//   req_op     per-requester op: 1=push, 0=pop
//   req_wdata  push data, requester i uses [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ack    one-hot, one-cycle completion pulse
//   rsp_valid  one-cycle pulse, pop data valid on rsp_data
//   rsp_idx    requester that owns the current rsp_valid
//   rsp_data   popped word, holds its value between pulses
//   rsp_err    (STK_ARB_ERR_EN only) the current ack was a rejected op
//   busy       high while a pop completion is in progress (RD state)
//   stk_push   stack push strobe
//   stk_pop    stack pop strobe
//   stk_din    stack write data
//   stk_dout   stack read data, registered by the stack on the pop edge
//   stk_full   stack full flag
//   stk_empty  stack empty flag
// -----------------------------------------------------------------------------
module stack_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          rsp_valid,
    output logic [IDX_WIDTH-1:0]          rsp_idx,
    output logic [DATA_WIDTH-1:0]         rsp_data,
`ifdef STK_ARB_ERR_EN
    output logic                          rsp_err,
`endif
    output logic                          busy,
    output logic                          stk_push,
    output logic                          stk_pop,
    output logic [DATA_WIDTH-1:0]         stk_din,
    input  logic [DATA_WIDTH-1:0]         stk_dout,
    input  logic                          stk_full,
    input  logic                          stk_empty
);

    localparam logic [0:0]           ST_ARB   = 1'b0;
    localparam logic [0:0]           ST_RD    = 1'b1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    logic [0:0]           state;
    logic [IDX_WIDTH-1:0] rr_ptr;

    logic [NUM_REQ-1:0]   op_ok;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_WIDTH-1:0] scan_pos;
    logic                 gnt_valid;
    logic [IDX_WIDTH-1:0] gnt_idx;
    logic                 gnt_is_push;
    logic                 gnt_op_ok;
    logic [IDX_WIDTH-1:0] rr_next;

    // -------------------------------------------------------------------------
    // Eligibility. A requester whose ack is showing this cycle is masked. It
    // may still hold req high while it reacts to the ack, and that must not
    // be taken as a second request.
    // -------------------------------------------------------------------------
    always_comb begin
        op_ok    = '0;
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            op_ok[i] = req_op[i] ? ~stk_full : ~stk_empty;
`ifdef STK_ARB_ERR_EN
            eligible[i] = req[i] & ~req_ack[i];
`else
            eligible[i] = req[i] & ~req_ack[i] & op_ok[i];
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin scan from rr_ptr, wrapping at NUM_REQ-1 (not at 2**IDX_WIDTH,
    // so non-power-of-two requester counts work).
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan_pos  = '0;
        if (reset_n && (state == ST_ARB)) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan_pos = IDX_WIDTH'((32'(rr_ptr) + k) % NUM_REQ);
                if (!gnt_valid && eligible[scan_pos]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = scan_pos;
                end
            end
        end
    end

    assign gnt_is_push = req_op[gnt_idx];
    assign gnt_op_ok   = op_ok[gnt_idx];
    assign rr_next     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Stack control pins. A rejected grant (error build only) drives nothing.
    // -------------------------------------------------------------------------
    assign stk_push = gnt_valid &  gnt_is_push & gnt_op_ok;
    assign stk_pop  = gnt_valid & ~gnt_is_push & gnt_op_ok;
    assign stk_din  = stk_push ? req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign busy = (state == ST_RD);

    // -------------------------------------------------------------------------
    // FSM and registered responses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            req_ack   <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_data  <= '0;
`ifdef STK_ARB_ERR_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= 1'b0;
`ifdef STK_ARB_ERR_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                ST_ARB: begin
                    if (gnt_valid) begin
                        rr_ptr <= rr_next;
                        if (stk_pop) begin
                            state   <= ST_RD;
                            rsp_idx <= gnt_idx;
                        end else begin
                            // Push, or a rejected op in the error build.
                            req_ack[gnt_idx] <= 1'b1;
                        end
`ifdef STK_ARB_ERR_EN
                        rsp_err <= ~gnt_op_ok;
`endif
                    end
                end
                ST_RD: begin
                    rsp_data         <= stk_dout;
                    rsp_valid        <= 1'b1;
                    req_ack[rsp_idx] <= 1'b1;
                    state            <= ST_ARB;
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
`timescale 1ns/1ps
module tb_stack_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;
    localparam int DEPTH = 16;
    localparam int NCYC  = 1500;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_op;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_idx;
    logic [DW-1:0]   rsp_data;
`ifdef STK_ARB_ERR_EN
    logic            rsp_err;
`endif
    logic            busy;
    logic            stk_push;
    logic            stk_pop;
    logic [DW-1:0]   stk_din;
    logic [DW-1:0]   stk_dout;
    logic            stk_full;
    logic            stk_empty;

    int checks = 0;
    int errors = 0;

    stack_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .IDX_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_op   (req_op),
        .req_wdata(req_wdata),
        .req_ack  (req_ack),
        .rsp_valid(rsp_valid),
        .rsp_idx  (rsp_idx),
        .rsp_data (rsp_data),
`ifdef STK_ARB_ERR_EN
        .rsp_err  (rsp_err),
`endif
        .busy     (busy),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_din  (stk_din),
        .stk_dout (stk_dout),
        .stk_full (stk_full),
        .stk_empty(stk_empty)
    );

    always #5 clk = ~clk;

    // Stack memory seen by the DUT: dout registered on the pop edge.
    logic [DW-1:0] smem [DEPTH];
    int            scnt  = 0;
    logic [DW-1:0] sdout = '0;

    assign stk_dout  = sdout;
    assign stk_full  = (scnt == DEPTH);
    assign stk_empty = (scnt == 0);

    always @(posedge clk) begin
        if (stk_push && scnt < DEPTH) begin
            smem[scnt] <= stk_din;
            scnt       <= scnt + 1;
        end else if (stk_pop && scnt > 0) begin
            sdout <= smem[scnt-1];
            scnt  <= scnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: requesters, a queue for the stack contents, a
    // round-robin start index and a "pop completing" flag.
    logic [N-1:0]  pend, op, infl;
    logic [DW-1:0] wd [N];
    logic [DW-1:0] mq [$];
    int            m_rr, m_ridx, g, push_pct, mid_rst;
    bit            m_rd, rst_now, ok_g;
    logic [DW-1:0] m_popped;
    logic [N-1:0]  exp_ack;
    bit            exp_rv, exp_err, exp_push, exp_pop;
    int            exp_ridx;
    logic [DW-1:0] exp_rdata, exp_din;

    function automatic bit op_fits(input bit is_push, input int depth_now);
        return is_push ? (depth_now < DEPTH) : (depth_now > 0);
    endfunction

    function automatic bit can_win(input bit is_push, input int depth_now);
`ifdef STK_ARB_ERR_EN
        return 1'b1;
`else
        return op_fits(is_push, depth_now);
`endif
    endfunction

    initial begin
        pend = '0; op = '0; infl = '0;
        for (int i = 0; i < N; i++) wd[i] = '0;
        m_rr = 0; m_rd = 0; m_ridx = 0; m_popped = '0; mid_rst = 0;
        exp_ack = '0; exp_rv = 0; exp_err = 0; exp_ridx = 0; exp_rdata = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            // Registered outputs, sampled 1ns after the edge.
            if (cyc > 0) begin
                check("req_ack", 32'(req_ack), 32'(exp_ack));
                check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
                if (exp_rv) check("rsp_idx", 32'(rsp_idx), 32'(exp_ridx));
                check("rsp_data", 32'(rsp_data), 32'(exp_rdata));
                check("busy", 32'(busy), 32'(m_rd));
`ifdef STK_ARB_ERR_EN
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
`endif
            end

            push_pct = (cyc < 400) ? 85 : (cyc < 800) ? 15 : 50;

            // Requesters: drop on ack, occasionally withdraw, otherwise start new work.
            for (int i = 0; i < N; i++) begin
                if (exp_ack[i]) begin
                    pend[i] = 1'b0;
                    infl[i] = 1'b0;
                end else if (pend[i] && !infl[i] && $urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    op[i]   = ($urandom_range(0, 99) < push_pct);
                    wd[i]   = 8'($urandom);
                end
            end

            if (cyc < 2) begin
                rst_now = 1'b1;
                pend    = '1;
                op      = '1;
            end else begin
                rst_now = (cyc >= 50) && m_rd &&
                          (($urandom_range(0, 24) == 0) || (cyc >= 900 && mid_rst == 0));
                if (rst_now) mid_rst++;
            end

            reset_n = ~rst_now;
            req     = pend;
            req_op  = op;
            for (int i = 0; i < N; i++) req_wdata[i*DW +: DW] = wd[i];
            #1;

            // Expected grant this cycle.
            g = -1;
            if (!rst_now && !m_rd) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (g < 0 && pend[idx] && can_win(op[idx], mq.size())) g = idx;
                end
            end
            ok_g     = (g >= 0) && op_fits(op[g], mq.size());
            exp_push = ok_g && op[g];
            exp_pop  = ok_g && !op[g];
            exp_din  = exp_push ? wd[g] : '0;
            check("stk_push", 32'(stk_push), 32'(exp_push));
            check("stk_pop", 32'(stk_pop), 32'(exp_pop));
            check("stk_din", 32'(stk_din), 32'(exp_din));

            // Expected registered outputs for the next cycle.
            exp_ack = '0;
            exp_rv  = 1'b0;
            exp_err = 1'b0;
            if (rst_now) begin
                m_rr = 0; m_rd = 0; exp_ridx = 0; exp_rdata = '0;
                pend = '0; infl = '0;
            end else if (m_rd) begin
                exp_rv          = 1'b1;
                exp_ack[m_ridx] = 1'b1;
                exp_ridx        = m_ridx;
                exp_rdata       = m_popped;
                m_rd            = 1'b0;
            end else if (g >= 0) begin
                m_rr    = (g + 1) % N;
                infl[g] = 1'b1;
                if (!ok_g) begin
                    exp_ack[g] = 1'b1;
                    exp_err    = 1'b1;
                end else if (op[g]) begin
                    mq.push_back(wd[g]);
                    exp_ack[g] = 1'b1;
                end else begin
                    m_popped = mq.pop_back();
                    m_rd     = 1'b1;
                    m_ridx   = g;
                end
            end

            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
